// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write bus.
//   byte_valid/byte_data/byte_ready : byte stream from the host (UART, bench)
//   wr_en/wr_addr/wr_data           : single-cycle word writes into imem
//   modport master : host / memory side (drives bytes, observes writes)
//   modport slave  : loader side (accepts bytes, issues writes)
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes
// them to instruction memory at sequential addresses from 0, stalling the core
// while the image loads.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, load_len   : begin a load of load_len words (legal: 1..MEM_WORDS)
//   bus (slave)       : byte stream in, imem write strobe/address/data out
//   word_count        : words written in the current or last load
//   cpu_stall         : high while a load is in progress
//   load_done         : level, last load completed
//   len_err           : sticky, last start carried an illegal load_len
//   checksum_err      : trailer mismatch (0 unless IMEM_LOADER_CHECKSUM_EN)
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a 4-byte trailer word
// follows the data and is compared against the XOR of all written words.
module imem_loader #(
    parameter int unsigned MEM_WORDS = 128,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] load_len,
    imem_loader_if.slave     bus,
    output logic [CNT_W-1:0] word_count,
    output logic             cpu_stall,
    output logic             load_done,
    output logic             len_err,
    output logic             checksum_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              byte_ready_q, byte_ready_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic              load_done_q, load_done_d;
    logic              len_err_q, len_err_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic              accept_c;
    logic              len_ok_c;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
    logic              trailer_q, trailer_d;
    logic              checksum_err_q, checksum_err_d;
`endif

    // Byte moves only while the registered ready is up, i.e. in RECV.
    assign accept_c = byte_ready_q && bus.byte_valid;
    assign len_ok_c = (load_len != '0) && (load_len <= CNT_W'(MEM_WORDS));

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        len_err_d    = len_err_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d         = csum_q;
        trailer_d      = trailer_q;
        checksum_err_d = checksum_err_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (len_ok_c) begin
                        len_d        = load_len;
                        word_count_d = '0;
                        wr_addr_d    = '0;
                        byte_idx_d   = 2'd0;
                        asm_d        = '0;
                        len_err_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d         = '0;
                        trailer_d      = 1'b0;
                        checksum_err_d = 1'b0;
`endif
                        state_d      = S_RECV;
                    end else begin
                        // Illegal length: flag it and stay put.
                        len_err_d = 1'b1;
                    end
                end
            end

            S_RECV: begin
                if (accept_c) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = bus.byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        if (trailer_q) begin
                            state_d = S_CHECK;
                        end else begin
                            wr_data_d = asm_d;
                            state_d   = S_WRITE;
                        end
`else
                        wr_data_d = asm_d;
                        state_d   = S_WRITE;
`endif
                    end
                end
            end

            S_WRITE: begin
                word_count_d = word_count_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ wr_data_q;
`endif
                if (word_count_d == len_q) begin
                    // Address stays on the last word so it never wraps.
`ifdef IMEM_LOADER_CHECKSUM_EN
                    trailer_d = 1'b1;
                    state_d   = S_RECV;
`else
                    state_d   = S_DONE;
`endif
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    state_d   = S_RECV;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            // Trailer fully assembled in asm_q; compare, no write.
            S_CHECK: begin
                checksum_err_d = (asm_q != csum_q);
                trailer_d      = 1'b0;
                state_d        = S_DONE;
            end
`endif

            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered.
        wr_en_d      = (state_d == S_WRITE);
        byte_ready_d = (state_d == S_RECV);
        cpu_stall_d  = (state_d == S_RECV) || (state_d == S_WRITE) ||
                       (state_d == S_CHECK);
        load_done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            byte_ready_q <= 1'b0;
            cpu_stall_q  <= 1'b0;
            load_done_q  <= 1'b0;
            len_err_q    <= 1'b0;
            byte_idx_q   <= 2'd0;
            asm_q        <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            byte_ready_q <= byte_ready_d;
            cpu_stall_q  <= cpu_stall_d;
            load_done_q  <= load_done_d;
            len_err_q    <= len_err_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum accumulator and trailer-phase flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q         <= '0;
            trailer_q      <= 1'b0;
            checksum_err_q <= 1'b0;
        end else begin
            csum_q         <= csum_d;
            trailer_q      <= trailer_d;
            checksum_err_q <= checksum_err_d;
        end
    end

    assign checksum_err = checksum_err_q;
`else
    assign checksum_err = 1'b0;
`endif

    assign bus.byte_ready = byte_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign word_count     = word_count_q;
    assign cpu_stall      = cpu_stall_q;
    assign load_done      = load_done_q;
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. The stimulus side pushes
// the expected (address, word) of every write; a monitor pops and compares on
// each wr_en. Directed loads plus randomized loads with random bubbles.
module tb_imem_loader;
    localparam int unsigned MEM_WORDS = 128;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned CNT_W     = 8;
    localparam int          WAIT_MAX  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] load_len;
    logic [CNT_W-1:0] word_count;
    logic             cpu_stall;
    logic             load_done;
    logic             len_err;
    logic             checksum_err;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .load_len     (load_len),
        .bus          (bus),
        .word_count   (word_count),
        .cpu_stall    (cpu_stall),
        .load_done    (load_done),
        .len_err      (len_err),
        .checksum_err (checksum_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(bus.wr_en), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    chk("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_byte_ready"},   64'(bus.byte_ready), 64'd0);
        chk({tag, "_wr_en"},        64'(bus.wr_en),      64'd0);
        chk({tag, "_wr_addr"},      64'(bus.wr_addr),    64'd0);
        chk({tag, "_wr_data"},      64'(bus.wr_data),    64'd0);
        chk({tag, "_word_count"},   64'(word_count),     64'd0);
        chk({tag, "_cpu_stall"},    64'(cpu_stall),      64'd0);
        chk({tag, "_load_done"},    64'(load_done),      64'd0);
        chk({tag, "_len_err"},      64'(len_err),        64'd0);
        chk({tag, "_checksum_err"}, 64'(checksum_err),   64'd0);
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int   n;
        logic ok;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < WAIT_MAX) begin
            @(negedge clk);
            ok = bus.byte_ready;
            tick();
            n++;
        end
        if (!ok) chk("byte_accept_timeout", 64'(ok), 64'd1);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = CNT_W'(len);
        tick();
        start    = 1'b0;
        load_len = CNT_W'($urandom);
    endtask

    // Loads words_q; gap<0 means random bubbles of 0..3 cycles per byte.
    task automatic load_words(input int gap, input logic [31:0] flip);
        int          len;
        logic [31:0] w;
        logic [31:0] x;
        len = words_q.size();
        x   = '0;
        do_start(len);
        @(negedge clk);
        chk("stall_after_start", 64'(cpu_stall),      64'd1);
        chk("ready_after_start", 64'(bus.byte_ready), 64'd1);
        chk("len_err_cleared",   64'(len_err),        64'd0);
        chk("done_cleared",      64'(load_done),      64'd0);
        chk("count_cleared",     64'(word_count),     64'd0);
        tick();
        for (int i = 0; i < len; i++) begin
            w = words_q[i];
            x = x ^ w;
            exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: w});
            for (int k = 0; k < 4; k++)
                send_byte(w[8*k +: 8], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
        if (CSUM_EN) begin
            w = x ^ flip;
            for (int k = 0; k < 4; k++)
                send_byte(w[8*k +: 8], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
        // Cycle N+1 after the final byte.
        @(negedge clk);
        chk("stall_before_done", 64'(cpu_stall), 64'd1);
        chk("done_not_early",    64'(load_done), 64'd0);
        chk("wr_en_last_cycle",  64'(bus.wr_en), CSUM_EN ? 64'd0 : 64'd1);
        // Cycle N+2.
        @(negedge clk);
        chk("load_done",        64'(load_done),      64'd1);
        chk("stall_released",   64'(cpu_stall),      64'd0);
        chk("word_count",       64'(word_count),     64'(len));
        chk("ready_in_done",    64'(bus.byte_ready), 64'd0);
        chk("checksum_err",     64'(checksum_err),   64'(CSUM_EN && (flip != 0)));
        chk("scoreboard_empty", 64'(exp_q.size()),   64'd0);
        tick();
    endtask

    task automatic check_illegal(input string tag, input logic exp_done);
        @(negedge clk);
        chk({tag, "_len_err"},    64'(len_err),        64'd1);
        chk({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
        chk({tag, "_cpu_stall"},  64'(cpu_stall),      64'd0);
        chk({tag, "_load_done"},  64'(load_done),      64'(exp_done));
        tick();
    endtask

    initial begin
        logic [31:0] w;
        reset          = 1'b1;
        start          = 1'b0;
        load_len       = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset("reset");
        tick();

        // Two-word program, no bubbles.
        words_q = {32'h00000013, 32'h00100093};
        load_words(0, 32'h0);

        // Illegal start from DONE keeps load_done.
        do_start(0);
        check_illegal("len0_in_done", 1'b1);

        // One word with three-cycle bubbles between bytes.
        words_q = {32'hDEADBEEF};
        load_words(3, 32'h0);

        // Illegal lengths from IDLE.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_start(0);
        check_illegal("len0", 1'b0);
        do_start(MEM_WORDS + 1);
        check_illegal("len129", 1'b0);

        // Full-depth load; legal start clears len_err.
        words_q = {};
        for (int i = 0; i < MEM_WORDS; i++) words_q.push_back($urandom);
        load_words(0, 32'h0);

        // Reset in the middle of word 1 of a 3-word load.
        do_start(3);
        w = $urandom;
        exp_q.push_back(wr_t'{addr: ADDR_W'(0), data: w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0);
        w = $urandom;
        for (int k = 0; k < 2; k++) send_byte(w[8*k +: 8], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset("midload_reset");
        chk("midload_scoreboard", 64'(exp_q.size()), 64'd0);
        tick();
        words_q = {32'hCAFEF00D};
        load_words(-1, 32'h0);

        // Randomized loads with random bubbles.
        for (int r = 0; r < 6; r++) begin
            words_q = {};
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) words_q.push_back($urandom);
            load_words(-1, ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'h0);
        end

        if (CSUM_EN) begin
            words_q = {32'h11111111, 32'h22222222};
            load_words(0, 32'h0);
            words_q = {32'h11111111, 32'h22222222};
            load_words(0, 32'h00000007);
        end

        repeat (4) tick();
        chk("final_scoreboard", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
